// File: rtl/mem_access_port_if.sv
// Signal bundle for mem_access_port: the core-side request/response signals
// and the arbiter-side lane. The slave modport is the port block's view; the
// master modport is the view of whatever drives it (core plus arbiter).
interface mem_access_port_if;
    // core side
    logic       start;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       err;

    // arbiter side
    logic       mem_rden;
    logic       mem_wren;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_acq;
    logic [7:0] mem_dq;

    modport master (
        output start,
        output we,
        output addr,
        output wdata,
        output mem_acq,
        output mem_dq,
        input  busy,
        input  done,
        input  rdata,
        input  err,
        input  mem_rden,
        input  mem_wren,
        input  mem_addr,
        input  mem_din
    );

    modport slave (
        input  start,
        input  we,
        input  addr,
        input  wdata,
        input  mem_acq,
        input  mem_dq,
        output busy,
        output done,
        output rdata,
        output err,
        output mem_rden,
        output mem_wren,
        output mem_addr,
        output mem_din
    );
endinterface

// File: rtl/mem_access_port.sv
// mem_access_port: turns a single-cycle core load/store strobe into a held
// request toward a shared RAM arbiter, waits for the grant, counts out the
// fixed read latency and reports completion with a one-cycle done pulse.
//
// Optional feature: define MEM_PORT_TIMEOUT_EN to abort a request that is
// never granted within TIMEOUT_CYC REQ-state cycles (err pulse, no done).
// Without it err is tied low and REQ waits for the grant indefinitely.
//
// All outputs come straight from flops. The request lines and the address/
// data toward the arbiter are loaded on the accepting edge and left alone
// until the transaction finishes, so the arbiter sees a stable request.
module mem_access_port #(
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_port_if.slave   bus
);

    // Value loaded into the latency counter on the grant. WAIT then runs
    // RD_LAT cycles, so done lands RD_LAT+1 cycles after the grant sample.
    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

`ifdef MEM_PORT_TIMEOUT_EN
    // REQ-cycle count at which the request is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    // registered outputs and their next values
    logic       busy_q,  busy_next;
    logic       done_q,  done_next;
    logic       rden_q,  rden_next;
    logic       wren_q,  wren_next;
    logic [7:0] addr_q,  addr_next;
    logic [7:0] din_q,   din_next;
    logic [7:0] rdata_q, rdata_next;

    // internal state
    logic       we_q,        we_next;
    logic [3:0] lat_cnt,     lat_cnt_next;
    logic       req_first,   req_first_next;

`ifdef MEM_PORT_TIMEOUT_EN
    logic       err_q,   err_next;
    logic [7:0] req_cnt, req_cnt_next;
`endif

    // State register; reset drops straight back to IDLE, abandoning any
    // transaction in flight without a done or err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode for the whole transaction sequence.
    always_comb begin
        state_next     = state;
        busy_next      = busy_q;
        done_next      = 1'b0;
        rden_next      = rden_q;
        wren_next      = wren_q;
        addr_next      = addr_q;
        din_next       = din_q;
        rdata_next     = rdata_q;
        we_next        = we_q;
        lat_cnt_next   = lat_cnt;
        req_first_next = req_first;
`ifdef MEM_PORT_TIMEOUT_EN
        err_next       = 1'b0;
        req_cnt_next   = req_cnt;
`endif

        case (state)
            IDLE: begin
                if (bus.start) begin
                    we_next        = bus.we;
                    addr_next      = bus.addr;
                    din_next       = bus.wdata;
                    wren_next      = bus.we;
                    rden_next      = ~bus.we;
                    busy_next      = 1'b1;
                    lat_cnt_next   = 4'd0;
                    req_first_next = 1'b1;
`ifdef MEM_PORT_TIMEOUT_EN
                    req_cnt_next   = 8'd0;
`endif
                    state_next     = REQ;
                end
            end

            REQ: begin
                // The first REQ cycle may still see a grant left over from a
                // previous owner of the lane, so the grant is only trusted
                // from the second REQ cycle on.
                req_first_next = 1'b0;
                if (!req_first && bus.mem_acq) begin
                    lat_cnt_next = LAT_LOAD;
                    state_next   = WAIT;
                end
`ifdef MEM_PORT_TIMEOUT_EN
                else if (req_cnt == TIMEOUT_LAST) begin
                    err_next     = 1'b1;
                    rden_next    = 1'b0;
                    wren_next    = 1'b0;
                    busy_next    = 1'b0;
                    req_cnt_next = 8'd0;
                    state_next   = IDLE;
                end else begin
                    req_cnt_next = req_cnt + 8'd1;
                end
`endif
            end

            WAIT: begin
                // The grant is not looked at here: once granted, the access
                // runs to completion even if the arbiter drops acq early.
                if (lat_cnt == 4'd0) begin
                    if (!we_q) begin
                        rdata_next = bus.mem_dq;
                    end
                    done_next  = 1'b1;
                    rden_next  = 1'b0;
                    wren_next  = 1'b0;
                    state_next = DONE;
                end else begin
                    lat_cnt_next = lat_cnt - 4'd1;
                end
            end

            DONE: begin
                // Requests were already dropped on entry; this cycle plus the
                // IDLE cycle guarantee a gap before the next request.
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                busy_next  = 1'b0;
                rden_next  = 1'b0;
                wren_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Output and datapath registers, cleared to all-zero by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            addr_q    <= 8'h00;
            din_q     <= 8'h00;
            rdata_q   <= 8'h00;
            we_q      <= 1'b0;
            lat_cnt   <= 4'd0;
            req_first <= 1'b0;
        end else begin
            busy_q    <= busy_next;
            done_q    <= done_next;
            rden_q    <= rden_next;
            wren_q    <= wren_next;
            addr_q    <= addr_next;
            din_q     <= din_next;
            rdata_q   <= rdata_next;
            we_q      <= we_next;
            lat_cnt   <= lat_cnt_next;
            req_first <= req_first_next;
        end
    end

`ifdef MEM_PORT_TIMEOUT_EN
    // Timeout bookkeeping: REQ-cycle counter and the err pulse flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= 1'b0;
            req_cnt <= 8'd0;
        end else begin
            err_q   <= err_next;
            req_cnt <= req_cnt_next;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_rden = rden_q;
    assign bus.mem_wren = wren_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;

endmodule

// File: tb/tb_mem_access_port.sv
// Directed testbench for mem_access_port with RD_LAT=2 and TIMEOUT_CYC=8.
// Inputs are driven and outputs sampled on the falling edge, half a cycle
// away from the rising edge the design acts on. The timeout sequence only
// runs when MEM_PORT_TIMEOUT_EN is defined.
module tb_mem_access_port;

    logic clk;
    logic rst;

    int checks;
    int errors;

    mem_access_port_if bus ();

    mem_access_port #(
        .RD_LAT      (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance to the next falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    // drive the core-side request inputs
    task automatic applyStimulus(input logic s, input logic w,
                                 input logic [7:0] a, input logic [7:0] d);
        bus.start = s;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    // one comparison: count it, flag it if the observed value differs
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // all outputs at their idle/reset values, apart from rdata
    task automatic checkIdle(input string tag, input logic [7:0] exp_rdata);
        checkOutput({tag, "_busy"},  bus.busy,     8'd0);
        checkOutput({tag, "_done"},  bus.done,     8'd0);
        checkOutput({tag, "_err"},   bus.err,      8'd0);
        checkOutput({tag, "_rden"},  bus.mem_rden, 8'd0);
        checkOutput({tag, "_wren"},  bus.mem_wren, 8'd0);
        checkOutput({tag, "_rdata"}, bus.rdata,    exp_rdata);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        bus.mem_acq = 1'b0;
        bus.mem_dq  = 8'h00;

        // ---------------- reset state ----------------
        tick();
        tick();
        checkIdle("rst", 8'h00);
        checkOutput("rst_addr", bus.mem_addr, 8'h00);
        checkOutput("rst_din",  bus.mem_din,  8'h00);
        rst = 1'b0;
        tick();

        // ---------------- load, grant on 3rd REQ cycle ----------------
        applyStimulus(1'b1, 1'b0, 8'h12, 8'h00);
        tick();                                    // REQ 1
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("ld_busy", bus.busy,     8'd1);
        checkOutput("ld_rden", bus.mem_rden, 8'd1);
        checkOutput("ld_wren", bus.mem_wren, 8'd0);
        checkOutput("ld_addr", bus.mem_addr, 8'h12);
        tick();                                    // REQ 2
        checkOutput("ld_req2_rden", bus.mem_rden, 8'd1);
        checkOutput("ld_req2_done", bus.done,     8'd0);
        tick();                                    // REQ 3
        bus.mem_acq = 1'b1;
        tick();                                    // WAIT, cnt 1
        bus.mem_acq = 1'b0;                        // early drop is ignored
        checkOutput("ld_w1_done", bus.done,     8'd0);
        checkOutput("ld_w1_rden", bus.mem_rden, 8'd1);
        checkOutput("ld_w1_addr", bus.mem_addr, 8'h12);
        tick();                                    // WAIT, cnt 0
        checkOutput("ld_w0_done", bus.done, 8'd0);
        bus.mem_dq = 8'hA5;
        tick();                                    // DONE
        bus.mem_dq = 8'hFF;
        checkOutput("ld_done",       bus.done,     8'd1);
        checkOutput("ld_rdata",      bus.rdata,    8'hA5);
        checkOutput("ld_done_rden",  bus.mem_rden, 8'd0);
        checkOutput("ld_done_busy",  bus.busy,     8'd1);
        checkOutput("ld_done_err",   bus.err,      8'd0);
        tick();                                    // IDLE
        checkIdle("ld_after", 8'hA5);

        // ---------------- store, start pulsed while busy ----------------
        bus.mem_dq = 8'h66;
        applyStimulus(1'b1, 1'b1, 8'h40, 8'h3C);
        tick();                                    // REQ 1
        applyStimulus(1'b1, 1'b0, 8'h77, 8'h11);   // must be ignored
        checkOutput("st_wren", bus.mem_wren, 8'd1);
        checkOutput("st_rden", bus.mem_rden, 8'd0);
        checkOutput("st_din",  bus.mem_din,  8'h3C);
        checkOutput("st_addr", bus.mem_addr, 8'h40);
        tick();                                    // REQ 2
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("st_req2_din",  bus.mem_din,  8'h3C);
        checkOutput("st_req2_addr", bus.mem_addr, 8'h40);
        checkOutput("st_req2_wren", bus.mem_wren, 8'd1);
        bus.mem_acq = 1'b1;
        tick();                                    // WAIT, cnt 1
        bus.mem_acq = 1'b0;
        checkOutput("st_w1_wren", bus.mem_wren, 8'd1);
        checkOutput("st_w1_din",  bus.mem_din,  8'h3C);
        tick();                                    // WAIT, cnt 0
        checkOutput("st_w0_done", bus.done, 8'd0);
        tick();                                    // DONE
        checkOutput("st_done",      bus.done,     8'd1);
        checkOutput("st_rdata",     bus.rdata,    8'hA5);
        checkOutput("st_done_wren", bus.mem_wren, 8'd0);
        tick();                                    // IDLE
        checkIdle("st_after", 8'hA5);
        tick();                                    // still IDLE, nothing queued
        checkIdle("st_noqueue", 8'hA5);
        checkOutput("st_noqueue_addr", bus.mem_addr, 8'h40);

        // ---------------- stale grant held before start ----------------
        bus.mem_acq = 1'b1;
        bus.mem_dq  = 8'h00;
        applyStimulus(1'b1, 1'b0, 8'h21, 8'h00);
        tick();                                    // REQ 1, acq ignored
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("stale_busy", bus.busy,     8'd1);
        checkOutput("stale_rden", bus.mem_rden, 8'd1);
        tick();                                    // REQ 2, acq sampled
        checkOutput("stale_req2_done", bus.done, 8'd0);
        tick();                                    // WAIT, cnt 1
        checkOutput("stale_w1_done", bus.done, 8'd0);
        tick();                                    // WAIT, cnt 0
        checkOutput("stale_w0_done", bus.done, 8'd0);
        bus.mem_dq = 8'hC3;
        tick();                                    // DONE
        bus.mem_acq = 1'b0;
        bus.mem_dq  = 8'h00;
        checkOutput("stale_done",  bus.done,  8'd1);
        checkOutput("stale_rdata", bus.rdata, 8'hC3);
        tick();                                    // IDLE
        checkIdle("stale_after", 8'hC3);

        // ---------------- reset in the middle of WAIT ----------------
        applyStimulus(1'b1, 1'b0, 8'h33, 8'h00);
        tick();                                    // REQ 1
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();                                    // REQ 2
        bus.mem_acq = 1'b1;
        tick();                                    // WAIT, cnt 1
        bus.mem_acq = 1'b0;
        checkOutput("mid_busy", bus.busy, 8'd1);
        #2 rst = 1'b1;
        #1;
        checkIdle("arst", 8'h00);
        checkOutput("arst_addr", bus.mem_addr, 8'h00);
        checkOutput("arst_din",  bus.mem_din,  8'h00);
        tick();
        rst = 1'b0;
        tick();
        checkIdle("arst_rel1", 8'h00);
        tick();
        checkIdle("arst_rel2", 8'h00);

        // fresh load after reset release
        applyStimulus(1'b1, 1'b0, 8'h55, 8'h00);
        tick();                                    // REQ 1
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("post_addr", bus.mem_addr, 8'h55);
        checkOutput("post_rden", bus.mem_rden, 8'd1);
        tick();                                    // REQ 2
        bus.mem_acq = 1'b1;
        tick();                                    // WAIT, cnt 1
        bus.mem_acq = 1'b0;
        tick();                                    // WAIT, cnt 0
        checkOutput("post_w0_done", bus.done, 8'd0);
        bus.mem_dq = 8'h99;
        tick();                                    // DONE
        bus.mem_dq = 8'h00;
        checkOutput("post_done",  bus.done,  8'd1);
        checkOutput("post_rdata", bus.rdata, 8'h99);
        tick();                                    // IDLE
        checkIdle("post_after", 8'h99);

`ifdef MEM_PORT_TIMEOUT_EN
        // ---------------- grant never arrives, timeout after 8 REQ cycles ----------------
        bus.mem_acq = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h0F, 8'h00);
        tick();                                    // REQ 1
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("to_req%0d_busy", k), bus.busy, 8'd1);
            checkOutput($sformatf("to_req%0d_err",  k), bus.err,  8'd0);
            checkOutput($sformatf("to_req%0d_done", k), bus.done, 8'd0);
            tick();
        end
        checkOutput("to_err",  bus.err,      8'd1);
        checkOutput("to_busy", bus.busy,     8'd0);
        checkOutput("to_rden", bus.mem_rden, 8'd0);
        checkOutput("to_done", bus.done,     8'd0);
        tick();
        checkIdle("to_after", 8'h99);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
